exec_unit: RTL
==============

# exec_unit

Single-issue execute/write-back stage that sits directly between instruction issue and the 16×16-bit register file. It accepts one decoded instruction at a time through a valid/ready handshake, reads two operands over the register file's combinational read ports, computes the result, and performs the write-back through the file's single write port. Single-cycle ALU ops take a fixed three-state path; multiply is a 16-cycle iterative shift-and-add.

## Interface
- DATA_W, 16, operand/result width
- ADDR_W, 4, register address width
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- clear  input  1  synchronous flush, active-high
- instr_valid  input  1  instruction present
- instr_ready  output  1  stage can accept
- instr_op  input  4  opcode
- instr_rd / instr_ra / instr_rb  input  ADDR_W  dest / src A / src B
- instr_imm  input  8  immediate (LDI only)
- rf_addr_a / rf_addr_b  output  ADDR_W  register file read addresses
- rf_data_a / rf_data_b  input  DATA_W  register file read data (combinational)
- rf_we  output  1  write-back strobe
- rf_waddr  output  ADDR_W  write-back address
- rf_wdata  output  DATA_W  write-back data
- flag_z, flag_c  output  1  zero / carry flags
- busy  output  1  state != IDLE

## Operation
- States: IDLE → EXEC → (MUL ×16 →) WB → IDLE.
- IDLE: instr_ready=1. On instr_valid && instr_ready, latch op/rd/ra/rb/imm → EXEC.
- EXEC: rf_addr_a/b driven from latched ra/rb; result and flags computed and registered; → WB (or → MUL for MUL).
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL by rf_data_b[3:0], 6 SHR (logical) by rf_data_b[3:0], 7 LDI rd ← {8'h00, imm}, 8 MUL (low 16 bits), 9 CMP (a−b, flags only), 10–15 NOP.
- ADD: carry = bit 16 of 17-bit sum. SUB/CMP: carry = borrow (a < b unsigned). Logic/shift/LDI/MUL: carry = 0.
- flag_z = (16-bit result == 0). Flags update at end of EXEC (MUL: end of last MUL cycle) for ops 0–9; NOP leaves flags unchanged.
- WB: rf_we = (state == WB) && write_op && !clear; write_op true for ops 0–8 only. rf_waddr/rf_wdata hold latched rd/result.
- MUL: operands latched in EXEC; 4-bit counter runs 16 iterations, one partial product per cycle.
- clear: in any non-IDLE state, next state IDLE, no write-back, flags unchanged. Clear in IDLE blocks acceptance that cycle (instr_ready=0 while clear=1).
- Reset values: state IDLE, instr_ready=1, busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_addr_a/b=0, flag_z=0, flag_c=0, counter=0.

## Timing
- Accept at edge k. ALU/LDI/CMP/NOP: EXEC cycle k+1, WB cycle k+2 (rf_we high for exactly one cycle), instr_ready high again from k+3.
- MUL: EXEC k+1, MUL k+2…k+17, WB k+18, ready k+19.
- Write data visible at register file on edge ending WB; the next instruction's EXEC reads it at earliest k+4, so no hazard forwarding is needed.
- Asynchronous reset deasserts rf_we and restores IDLE immediately, including mid-WB or mid-MUL.

## Configuration
- MUL_EN: defined → opcode 8 uses the iterative multiplier as above. Undefined → multiplier and MUL state not built; opcode 8 behaves as NOP (no write, flags unchanged, ALU latency).

## Structure
- exec_pkg: opcode constants (OP_ADD…OP_CMP), state encoding, DATA_W/ADDR_W defaults.
- One sub-module: exec_mul (start/done iterative shift-and-add, 16 cycles), instantiated only under MUL_EN.

## Test plan
- LDI r1,0x12; LDI r2,0x34; ADD r3,r1,r2 → WB: rf_waddr=3, rf_wdata=0x0046, flag_z=0, flag_c=0; ready 3 cycles after accept.
- r1=0xFFFF, r2=0x0001, ADD r4 → rf_wdata=0x0000, flag_z=1, flag_c=1; then CMP r1,r1 → no rf_we, flag_z=1, flag_c=0.
- r1=3, r2=5, SUB r5,r1,r2 → rf_wdata=0xFFFE, flag_c=1; SHL r6,r1,r2 (shift 5) → 0x0060.
- MUL r7,r1=0x0003,r2=0x0007 → rf_wdata=0x0015 at cycle k+18; with MUL_EN undefined → no rf_we, ready at k+3.
- clear=1 during 5th MUL cycle → no rf_we, busy=0 next cycle, flags unchanged; clear=1 in WB → rf_we stays 0.
- reset=0 asserted mid-WB → rf_we=0 and instr_ready=1 without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcodes, state encoding and width defaults for the execute/write-back stage.
// MUL_EN selects whether opcode 8 is a real multiply or a NOP.
package exec_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_LDI = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_CMP = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   // Ops whose flags settle at the end of EXEC (MUL settles later, NOPs never).
   function automatic logic is_alu_flag_op(input logic [3:0] op);
      return (op <= OP_LDI) || (op == OP_CMP);
   endfunction

   function automatic logic is_write_op(input logic [3:0] op);
`ifdef MUL_EN
      return op <= OP_MUL;
`else
      return op <= OP_LDI;
`endif
   endfunction

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-and-add multiplier, one partial product per cycle, low DATA_W bits kept.
// Only instantiated when MUL_EN is defined.
module exec_mul
   import exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] product,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] mcand_r;
   logic [DATA_W-1:0] mplier_r;
   logic [DATA_W-1:0] acc_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              run_r;
   logic [DATA_W-1:0] partial_s;

   // Partial product for the current multiplier bit.
   always_comb begin
      if (mplier_r[0]) begin
         partial_s = mcand_r;
      end else begin
         partial_s = '0;
      end
   end

   // product is already final during the last iteration so the caller can register it then.
   assign product = acc_r + partial_s;
   assign done    = run_r && (cnt_r == CNT_LAST);

   // Operand capture and iteration state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         cnt_r    <= '0;
         run_r    <= 1'b0;
      end else if (clear) begin
         cnt_r    <= '0;
         run_r    <= 1'b0;
      end else if (start) begin
         mcand_r  <= op_a;
         mplier_r <= op_b;
         acc_r    <= '0;
         cnt_r    <= '0;
         run_r    <= 1'b1;
      end else if (run_r) begin
         acc_r    <= product;
         mcand_r  <= mcand_r << 1'b1;
         mplier_r <= mplier_r >> 1'b1;
         if (done) begin
            cnt_r <= '0;
            run_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/exec_unit.sv
// Single-issue execute/write-back stage between issue and a 16x16 register file.
// MUL_EN builds the iterative multiplier; otherwise opcode 8 is a NOP.
module exec_unit
   import exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_rd,
   input  logic [ADDR_W-1:0] instr_ra,
   input  logic [ADDR_W-1:0] instr_rb,
   input  logic [7:0]        instr_imm,
   output logic [ADDR_W-1:0] rf_addr_a,
   output logic [ADDR_W-1:0] rf_addr_b,
   input  logic [DATA_W-1:0] rf_data_a,
   input  logic [DATA_W-1:0] rf_data_b,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              flag_z,
   output logic              flag_c,
   output logic              busy
);

   state_t            state_r;
   state_t            state_nx_s;
   logic [3:0]        op_r;
   logic [ADDR_W-1:0] rd_r;
   logic [ADDR_W-1:0] ra_r;
   logic [ADDR_W-1:0] rb_r;
   logic [7:0]        imm_r;
   logic [DATA_W-1:0] result_r;
   logic              flag_z_r;
   logic              flag_c_r;
   logic              accept_s;
   logic [DATA_W:0]   sum_s;
   logic [DATA_W:0]   diff_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              alu_c_s;

   assign instr_ready = (state_r == ST_IDLE) && !clear;
   assign accept_s    = instr_valid && instr_ready;
   assign busy        = (state_r != ST_IDLE);
   assign rf_we       = (state_r == ST_WB) && is_write_op(op_r) && !clear;
   assign rf_waddr    = rd_r;
   assign rf_wdata    = result_r;
   assign rf_addr_a   = ra_r;
   assign rf_addr_b   = rb_r;
   assign flag_z      = flag_z_r;
   assign flag_c      = flag_c_r;

`ifdef MUL_EN
   logic              mul_start_s;
   logic [DATA_W-1:0] mul_prod_s;
   logic              mul_done_s;

   assign mul_start_s = (state_r == ST_EXEC) && (op_r == OP_MUL) && !clear;

   exec_mul #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .start   (mul_start_s),
      .op_a    (rf_data_a),
      .op_b    (rf_data_b),
      .product (mul_prod_s),
      .done    (mul_done_s)
   );
`endif

   // Single-cycle ALU; the carry is bit DATA_W of the widened sum or the borrow of the difference.
   always_comb begin
      sum_s     = {1'b0, rf_data_a} + {1'b0, rf_data_b};
      diff_s    = {1'b0, rf_data_a} - {1'b0, rf_data_b};
      alu_res_s = '0;
      alu_c_s   = 1'b0;
      case (op_r)
         OP_ADD: begin
            alu_res_s = sum_s[DATA_W-1:0];
            alu_c_s   = sum_s[DATA_W];
         end
         OP_SUB, OP_CMP: begin
            alu_res_s = diff_s[DATA_W-1:0];
            alu_c_s   = diff_s[DATA_W];
         end
         OP_AND:  alu_res_s = rf_data_a & rf_data_b;
         OP_OR:   alu_res_s = rf_data_a | rf_data_b;
         OP_XOR:  alu_res_s = rf_data_a ^ rf_data_b;
         OP_SHL:  alu_res_s = rf_data_a << rf_data_b[3:0];
         OP_SHR:  alu_res_s = rf_data_a >> rf_data_b[3:0];
         OP_LDI:  alu_res_s = {{(DATA_W-8){1'b0}}, imm_r};
         default: begin
            alu_res_s = '0;
            alu_c_s   = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state; clear aborts any in-flight instruction back to IDLE.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s = ST_EXEC;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (clear) begin
               state_nx_s = ST_IDLE;
`ifdef MUL_EN
            end else if (op_r == OP_MUL) begin
               state_nx_s = ST_MUL;
`endif
            end else begin
               state_nx_s = ST_WB;
            end
         end
`ifdef MUL_EN
         ST_MUL: begin
            if (clear) begin
               state_nx_s = ST_IDLE;
            end else if (mul_done_s) begin
               state_nx_s = ST_WB;
            end else begin
               state_nx_s = ST_MUL;
            end
         end
`endif
         ST_WB:   state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Instruction latch, result and flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_r     <= '0;
         rd_r     <= '0;
         ra_r     <= '0;
         rb_r     <= '0;
         imm_r    <= '0;
         result_r <= '0;
         flag_z_r <= 1'b0;
         flag_c_r <= 1'b0;
      end else begin
         if (accept_s) begin
            op_r  <= instr_op;
            rd_r  <= instr_rd;
            ra_r  <= instr_ra;
            rb_r  <= instr_rb;
            imm_r <= instr_imm;
         end
         if ((state_r == ST_EXEC) && !clear && is_alu_flag_op(op_r)) begin
            flag_z_r <= (alu_res_s == '0);
            flag_c_r <= alu_c_s;
            if (op_r != OP_CMP) begin
               result_r <= alu_res_s;
            end
         end
`ifdef MUL_EN
         if ((state_r == ST_MUL) && !clear && mul_done_s) begin
            result_r <= mul_prod_s;
            flag_z_r <= (mul_prod_s == '0);
            flag_c_r <= 1'b0;
         end
`endif
      end
   end

endmodule
